// File: rtl/clip_mem_sequencer_if.sv
// Memory, deserializer and serializer signals of the clip memory sequencer.
// master = sequencer side, slave = memory/serializer/deserializer side.
interface clip_mem_sequencer_if #(
  parameter int OFF_W  = 14,
  parameter int DATA_W = 16
);
  logic [OFF_W:0]    mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              des_valid;
  logic [DATA_W-1:0] des_data;
  logic              ser_ready;
  logic [DATA_W-1:0] ser_data;
  logic              ser_load;

  modport master (
    output mem_addr, mem_en, mem_we, mem_wdata, ser_data, ser_load,
    input  mem_rdata, des_valid, des_data, ser_ready
  );

  modport slave (
    input  mem_addr, mem_en, mem_we, mem_wdata, ser_data, ser_load,
    output mem_rdata, des_valid, des_data, ser_ready
  );
endinterface

// File: rtl/clip_mem_sequencer.sv
// Address/handshake sequencer between the record/play controller and the two-block clip memory.
// Build macro CLIP_LEN_TRACK_EN keeps per-block recorded lengths and limits playback to them.
module clip_mem_sequencer #(
  parameter int CLIP_WORDS = 16000,
  parameter int OFF_W      = 14,
  parameter int DATA_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 timer,
  input  logic [1:0]           memoryselect,
  output logic                 seconds2,
  output logic                 busy,
  clip_mem_sequencer_if.master bus
);
  localparam int OW1 = OFF_W + 1;
  localparam logic [OFF_W:0] LAST_OFF = OW1'(CLIP_WORDS - 1);

  if ((2 ** OFF_W) < CLIP_WORDS || DATA_W < 1) begin : g_param_check
    $error("clip_mem_sequencer: OFF_W too small for CLIP_WORDS or DATA_W invalid");
  end

  typedef enum logic [2:0] {IDLE, REC, RD, RDW, FIN, WAITLOW} state_t;

  state_t         state;
  logic           timer_q;
  logic           blk;
  logic [OFF_W:0] off;
  logic           rd_last;

`ifdef CLIP_LEN_TRACK_EN
  localparam logic [OFF_W:0] FULL_LEN = OW1'(CLIP_WORDS);
  logic [OFF_W:0] len [2];
  assign rd_last = (off + 1'b1) == len[blk];
`else
  assign rd_last = (off == LAST_OFF);
`endif

  // The memory is read combinationally from the registered address strobed in RDW,
  // so the word is captured at the end of that same RDW cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      timer_q       <= 1'b0;
      blk           <= 1'b0;
      off           <= '0;
      busy          <= 1'b0;
      seconds2      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.ser_data  <= '0;
      bus.ser_load  <= 1'b0;
`ifdef CLIP_LEN_TRACK_EN
      len[0]        <= '0;
      len[1]        <= '0;
`endif
    end else begin
      timer_q      <= timer;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.ser_load <= 1'b0;
      seconds2     <= 1'b0;
      case (state)
        IDLE: begin
          if (timer && !timer_q) begin
            blk  <= memoryselect[1];
            off  <= '0;
            busy <= 1'b1;
            if (memoryselect[0]) state <= REC;
`ifdef CLIP_LEN_TRACK_EN
            else if (len[memoryselect[1]] == '0) state <= FIN;
`endif
            else state <= RD;
          end
        end
        REC: begin
          if (!timer) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef CLIP_LEN_TRACK_EN
            len[blk] <= off;
`endif
          end else if (bus.des_valid) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {blk, off[OFF_W-1:0]};
            bus.mem_wdata <= bus.des_data;
            off           <= off + 1'b1;
            if (off == LAST_OFF) begin
              state <= FIN;
`ifdef CLIP_LEN_TRACK_EN
              len[blk] <= FULL_LEN;
`endif
            end
          end
        end
        RD: begin
          if (!timer) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.ser_ready) begin
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= {blk, off[OFF_W-1:0]};
            state        <= RDW;
          end
        end
        RDW: begin
          if (!timer) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            bus.ser_data <= bus.mem_rdata;
            bus.ser_load <= 1'b1;
            off          <= off + 1'b1;
            state        <= rd_last ? FIN : RD;
          end
        end
        FIN: begin
          seconds2 <= 1'b1;
          state    <= WAITLOW;
        end
        WAITLOW: begin
          if (!timer) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clip_mem_sequencer.sv
// Testbench for clip_mem_sequencer: directed vector table, reset/abort sequences and random sessions
// against a transaction-level model of clip memory contents and recorded lengths.
module tb_clip_mem_sequencer;
  localparam int CW = 8;
  localparam int OW = 3;
  localparam int DW = 16;

  logic       clock = 1'b0;
  logic       reset, timer, seconds2, busy;
  logic [1:0] memoryselect;
  int         checks = 0;
  int         failures = 0;

  clip_mem_sequencer_if #(.OFF_W(OW), .DATA_W(DW)) bus ();

  clip_mem_sequencer #(.CLIP_WORDS(CW), .OFF_W(OW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .timer(timer), .memoryselect(memoryselect),
    .seconds2(seconds2), .busy(busy), .bus(bus)
  );

  always #5 clock = ~clock;

  // Memory with combinational read and write on the rising edge.
  logic [DW-1:0] mem [2*CW] = '{default: '0};
  always @(posedge clock) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Reference: what each block should hold and how many words each block last recorded.
  logic [DW-1:0] ref_mem [2*CW] = '{default: '0};
  int            ref_len [2] = '{0, 0};

  logic [OW:0]   wr_a [$];
  logic [DW-1:0] wr_d [$];
  logic [OW:0]   rd_a [$];
  logic [DW-1:0] ld_d [$];
  int            ld_c [$];
  int            s2_cnt, s2_cyc, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_a.delete(); wr_d.delete(); rd_a.delete(); ld_d.delete(); ld_c.delete();
    s2_cnt = 0; s2_cyc = -1; cyc = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (bus.mem_en && bus.mem_we) begin wr_a.push_back(bus.mem_addr); wr_d.push_back(bus.mem_wdata); end
    if (bus.mem_en && !bus.mem_we) rd_a.push_back(bus.mem_addr);
    if (bus.ser_load) begin ld_d.push_back(bus.ser_data); ld_c.push_back(cyc); end
    if (seconds2) begin s2_cnt++; s2_cyc = cyc; end
  endtask

  function automatic int play_len(input logic b);
`ifdef CLIP_LEN_TRACK_EN
    return ref_len[b];
`else
    return CW;
`endif
  endfunction

  task automatic close_session(input bit done);
    if (done) begin
      bus.des_valid = 1'b1; bus.ser_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("busy_hold", busy, 1);
    end
    timer = 1'b0; bus.des_valid = 1'b0; bus.ser_ready = 1'b0;
    tick(); tick();
    chk("busy_idle", busy, 0);
  endtask

  task automatic rec_session(input logic b, input int nwords, input int gap, input bit rnd,
                             input int abort_n, input logic [DW-1:0] base,
                             output int nwr, output int ns2);
    int delivered = 0;
    int guard = 0;
    int exp_n;
    bit aborted = 1'b0;
    clear_mon();
    memoryselect = {b, 1'b1};
    timer = 1'b1;
    bus.des_valid = 1'b1; bus.des_data = 16'hdead;
    tick();
    while (guard < 300) begin
      guard++;
      memoryselect = 2'($urandom);
      if (abort_n >= 0 && delivered == abort_n) begin
        timer = 1'b0; bus.des_valid = 1'b1; bus.des_data = 16'hbeef; aborted = 1'b1;
        tick(); tick();
        break;
      end
      if (delivered < nwords && (rnd ? ($urandom_range(0, 1) == 1) : ((guard - 1) % (gap + 1) == 0))) begin
        bus.des_valid = 1'b1; bus.des_data = base + DW'(delivered); delivered++;
      end else bus.des_valid = 1'b0;
      tick();
      if (delivered >= nwords && s2_cnt > 0) break;
    end
    bus.des_valid = 1'b0;
    chk("rec_timeout", 32'(guard >= 300), 0);
    exp_n = (delivered < CW) ? delivered : CW;
    chk("rec_count", wr_a.size(), exp_n);
    for (int k = 0; k < exp_n && k < wr_a.size(); k++) begin
      chk("rec_addr", wr_a[k], {b, OW'(k)});
      chk("rec_data", wr_d[k], base + DW'(k));
    end
    for (int k = 0; k < exp_n; k++) ref_mem[{b, OW'(k)}] = base + DW'(k);
    ref_len[b] = exp_n;
    chk("rec_s2", s2_cnt, aborted ? 0 : 1);
    close_session(!aborted);
    chk("rec_count_after", wr_a.size(), exp_n);
    nwr = wr_a.size(); ns2 = s2_cnt;
  endtask

  task automatic play_session(input logic b, input bit rnd, input int abort_n, input bit on_strobe,
                              output int nld, output int ns2);
    int L = play_len(b);
    int guard = 0;
    int exp_ld, exp_rd;
    bit aborted = 1'b0;
    clear_mon();
    memoryselect = {b, 1'b0};
    timer = 1'b1; bus.ser_ready = 1'b1;
    tick();
    while (guard < 400) begin
      guard++;
      memoryselect = 2'($urandom);
      bus.ser_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (abort_n >= 0 && (on_strobe ? rd_a.size() : ld_d.size()) == abort_n) begin
        timer = 1'b0; aborted = 1'b1;
        tick(); tick();
        break;
      end
      if (s2_cnt > 0) break;
    end
    chk("play_timeout", 32'(guard >= 400), 0);
    exp_rd = aborted ? abort_n : L;
    exp_ld = aborted ? (on_strobe ? abort_n - 1 : abort_n) : L;
    chk("play_reads", rd_a.size(), exp_rd);
    chk("play_loads", ld_d.size(), exp_ld);
    for (int k = 0; k < rd_a.size() && k < exp_rd; k++) chk("play_addr", rd_a[k], {b, OW'(k)});
    for (int k = 0; k < ld_d.size() && k < exp_ld; k++) chk("play_data", ld_d[k], ref_mem[{b, OW'(k)}]);
    if (!rnd && !aborted)
      for (int k = 1; k < ld_c.size(); k++) chk("load_spacing", ld_c[k] - ld_c[k-1], 2);
    if (L == 0) chk("empty_s2_latency", s2_cyc, 2);
    chk("play_s2", s2_cnt, aborted ? 0 : 1);
    close_session(!aborted);
    chk("play_reads_after", rd_a.size(), exp_rd);
    chk("play_loads_after", ld_d.size(), exp_ld);
    nld = ld_d.size(); ns2 = s2_cnt;
  endtask

  typedef struct {
    string         name;
    logic [1:0]    ms;
    int            nwords;
    int            gap;
    int            abort_n;
    bit            on_strobe;
    logic [DW-1:0] base;
    int            exp_xfer;
    int            exp_s2;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int   nx, ns, an, nw, L, d, g;
    logic b;

    vecs[0] = '{name:"rec_blk1",      ms:2'b01, nwords:8,  gap:1, abort_n:-1, on_strobe:1'b0, base:16'h1000, exp_xfer:8, exp_s2:1};
    vecs[1] = '{name:"rec_blk2",      ms:2'b11, nwords:8,  gap:1, abort_n:-1, on_strobe:1'b0, base:16'h2000, exp_xfer:8, exp_s2:1};
    vecs[2] = '{name:"play_blk1",     ms:2'b00, nwords:0,  gap:0, abort_n:-1, on_strobe:1'b0, base:16'h0,    exp_xfer:8, exp_s2:1};
    vecs[3] = '{name:"play_abort_ld", ms:2'b00, nwords:0,  gap:0, abort_n:3,  on_strobe:1'b0, base:16'h0,    exp_xfer:3, exp_s2:0};
    vecs[4] = '{name:"play_abort_rd", ms:2'b10, nwords:0,  gap:0, abort_n:3,  on_strobe:1'b1, base:16'h0,    exp_xfer:2, exp_s2:0};
    vecs[5] = '{name:"rec_overrun",   ms:2'b01, nwords:10, gap:0, abort_n:-1, on_strobe:1'b0, base:16'h6000, exp_xfer:8, exp_s2:1};
    vecs[6] = '{name:"play_blk2",     ms:2'b10, nwords:0,  gap:0, abort_n:-1, on_strobe:1'b0, base:16'h0,    exp_xfer:8, exp_s2:1};

    reset = 1'b1; timer = 1'b1; memoryselect = 2'b01;
    bus.des_valid = 1'b1; bus.des_data = 16'h1234; bus.ser_ready = 1'b1;
    clear_mon();
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_s2", seconds2, 0);
    chk("rst_addr", bus.mem_addr, 0);
    reset = 1'b0; timer = 1'b0; bus.des_valid = 1'b0; bus.ser_ready = 1'b0;
    tick(); tick();
    chk("idle_quiet", wr_a.size() + rd_a.size() + ld_d.size() + s2_cnt, 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ms[0])
        rec_session(vecs[i].ms[1], vecs[i].nwords, vecs[i].gap, 1'b0, vecs[i].abort_n, vecs[i].base, nx, ns);
      else
        play_session(vecs[i].ms[1], 1'b0, vecs[i].abort_n, vecs[i].on_strobe, nx, ns);
      chk({vecs[i].name, "_xfers"}, nx, vecs[i].exp_xfer);
      chk({vecs[i].name, "_s2"}, ns, vecs[i].exp_s2);
    end

    // Reset during a record once four words have been written, with a word offered at the same edge.
    clear_mon();
    memoryselect = 2'b01; timer = 1'b1; bus.des_valid = 1'b0;
    tick();
    d = 0; g = 0;
    while (wr_a.size() < 4 && g < 100) begin
      g++;
      bus.des_valid = (g % 2 == 1);
      if (bus.des_valid) begin bus.des_data = 16'h3000 + DW'(d); d++; end
      tick();
    end
    reset = 1'b1; timer = 1'b0; bus.des_valid = 1'b1; bus.des_data = 16'h3abc;
    tick();
    chk("midrst_mem_en", bus.mem_en, 0);
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_ser_load", bus.ser_load, 0);
    chk("midrst_s2", seconds2, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_wdata", bus.mem_wdata, 0);
    chk("midrst_ser_data", bus.ser_data, 0);
    chk("midrst_writes", wr_a.size(), 4);
    for (int k = 0; k < 4; k++) ref_mem[k] = 16'h3000 + DW'(k);
    ref_len[0] = 0; ref_len[1] = 0;
    reset = 1'b0; bus.des_valid = 1'b0;
    tick();
    rec_session(1'b0, 8, 1, 1'b0, -1, 16'h4000, nx, ns);

    // Block 2 has not been recorded since reset, then gets a partial recording.
    play_session(1'b1, 1'b0, -1, 1'b0, nx, ns);
    rec_session(1'b1, 3, 1, 1'b0, 3, 16'h5000, nx, ns);
    chk("partial_writes", nx, 3);
    play_session(1'b1, 1'b0, -1, 1'b0, nx, ns);
    chk("partial_play_s2", ns, 1);

    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        an = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CW - 1)) : -1;
        nw = (an >= 0) ? an + int'($urandom_range(0, 3)) : CW + int'($urandom_range(0, 2));
        rec_session(b, nw, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), an, 16'($urandom), nx, ns);
      end else begin
        L = play_len(b);
        an = (L > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, L - 1)) : -1;
        play_session(b, 1'($urandom_range(0, 1)), an, 1'($urandom_range(0, 1)), nx, ns);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule
